// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the instruction-fetch requester and
// the load/store requester. Both ports are arbitrated round-robin. Only one
// transaction is in flight at a time. A read holds the arbiter for a fixed
// MEM_LAT cycles, after which the read data is steered back to the port that
// issued it. A write is fire-and-forget, so writes can issue back to back.
//
// Parameters
//   AW       address width
//   DW       data width (multiple of 8)
//   MEM_LAT  memory read latency in cycles, 1..8
//
// Ports
//   clk, rst                    clock; synchronous active-low reset
//   if_req/if_addr              fetch read request and byte address
//   if_gnt                      fetch request accepted this cycle
//   if_rvalid/if_rdata          fetch read data return
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb             load/store request (d_we = 1 means write)
//   d_gnt                       data request accepted this cycle
//   d_rvalid/d_rdata            data read data return (reads only)
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_wstrb         memory access strobe and command
//   mem_rdata                   memory read data, valid MEM_LAT cycles after
//                               a read strobe
//   busy                        a read is in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,

  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,

  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata,

  output logic            busy
);

  localparam int SW  = DW / 8;
  // Wide enough to hold MEM_LAT-1 for every legal latency.
  localparam int LCW = $clog2(MEM_LAT + 1);
  localparam logic [LCW-1:0] LAT_LOAD = LCW'(MEM_LAT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  state_e           state_q, state_d;
  logic [LCW-1:0]   lat_cnt_q, lat_cnt_d;
  port_e            owner_q, owner_d;
  port_e            last_q, last_d;

  logic             arb_ok;
  logic             if_win;
  logic             d_win;
  logic             rd_done;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants only come out of IDLE with reset released. On a tie
  // the port that did not win last time goes first, which bounds any port's
  // wait to one foreign transaction.
  // ---------------------------------------------------------------------------
  assign arb_ok  = rst && (state_q == IDLE);
  assign if_win  = arb_ok && if_req && (!d_req || (last_q == PORT_D));
  assign d_win   = arb_ok && d_req  && (!if_req || (last_q == PORT_IF));

  // Last cycle of the read latency: memory data is valid now. Gated by rst so
  // a read in flight when reset arrives is silently dropped.
  assign rd_done = rst && (state_q == WAIT) && (lat_cnt_q == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;

    unique case (state_q)
      IDLE: begin
        if (if_win || d_win) begin
          last_d = d_win ? PORT_D : PORT_IF;
          // Writes complete in the grant cycle; only reads occupy the memory.
          if (if_win || !d_we) begin
            state_d   = WAIT;
            lat_cnt_d = LAT_LOAD;
            owner_d   = d_win ? PORT_D : PORT_IF;
          end
        end
      end

      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LCW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. last resets to the data port so fetch wins the first tie.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      owner_q   <= PORT_IF;
      last_q    <= PORT_D;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory command. Address and write data come from the winner; outside a
  // grant they are don't-care, but mem_we is always held low then.
  // ---------------------------------------------------------------------------
  assign if_gnt    = if_win;
  assign d_gnt     = d_win;

  assign mem_en    = if_win || d_win;
  assign mem_we    = d_win && d_we;
  assign mem_addr  = d_win ? d_addr : if_addr;
  assign mem_wdata = d_wdata;
  assign mem_wstrb = d_win ? d_wstrb : {SW{1'b0}};

  // ---------------------------------------------------------------------------
  // Response steering. Both data buses carry the memory output; rvalid tells
  // the owner when it is meaningful.
  // ---------------------------------------------------------------------------
  assign if_rvalid = rd_done && (owner_q == PORT_IF);
  assign d_rvalid  = rd_done && (owner_q == PORT_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign busy      = rst && (state_q == WAIT);

endmodule
